// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives the instruction bus, holds one instruction for decode.
// Optional misaligned-fetch trapping is compiled in with FETCH_ADEL_EN.
module fetch_ctrl #(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'hBFC00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             br_take,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_flush,
  input  logic [WIDTH-1:0] exc_target,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic [WIDTH-1:0] pc_f,
  output logic             inst_valid_f,
  output logic [WIDTH-1:0] inst_f,
  output logic             adel_f,
  output logic [1:0]       fsm_state
);

  // Bus handshake: a request is a transfer on any cycle where inst_req and inst_addr_ok are both
  // high; inst_addr must not change until then. Exactly one response (inst_data_ok) follows each
  // accepted request, and it is only looked at in WAIT.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] pc_nx, inst_nx, pend_tgt, pend_tgt_nx;
  logic             adel_q, adel_nx, cancel, cancel_nx;
  logic             pend_exc, pend_exc_nx, pend_br, pend_br_nx;
  logic             load_pc, misaligned;
  logic             redir_exc, redir_br;
  logic [WIDTH-1:0] exc_tgt, br_tgt, next_pc;

`ifdef FETCH_ADEL_EN
  assign misaligned = (pc_f[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A current request takes precedence over the pending one of the same kind.
  assign redir_exc = exc_flush | pend_exc;
  assign exc_tgt   = exc_flush ? exc_target : pend_tgt;
  assign redir_br  = br_take | pend_br;
  assign br_tgt    = br_take ? br_target : pend_tgt;
  assign next_pc   = redir_exc ? exc_tgt : (redir_br ? br_tgt : pc_f + WIDTH'(4));

  assign inst_req     = (state == REQ) && !misaligned;
  assign inst_addr    = pc_f;
  assign inst_valid_f = (state == HOLD);
  assign adel_f       = adel_q;
  assign fsm_state    = state;

  always_comb begin
    state_nx  = state;
    pc_nx     = pc_f;
    inst_nx   = inst_f;
    adel_nx   = adel_q;
    cancel_nx = cancel;
    load_pc   = 1'b0;
    case (state)
      IDLE: begin
        state_nx = REQ;
        if (exc_flush) begin
          pc_nx   = exc_target;
          load_pc = 1'b1;
        end
      end
      REQ: begin
        if (misaligned) begin
          if (redir_exc) begin
            pc_nx   = exc_tgt;
            load_pc = 1'b1;
          end else begin
            state_nx = HOLD;
            inst_nx  = '0;
            adel_nx  = 1'b1;
          end
        end else if (inst_addr_ok) begin
          // The address is already on the bus; an exception can only discard its response.
          state_nx  = WAIT;
          cancel_nx = redir_exc;
        end
      end
      WAIT: begin
        if (inst_data_ok) begin
          if (cancel || exc_flush) begin
            pc_nx     = exc_tgt;
            load_pc   = 1'b1;
            cancel_nx = 1'b0;
            state_nx  = REQ;
          end else begin
            inst_nx  = inst_rdata;
            adel_nx  = 1'b0;
            state_nx = HOLD;
          end
        end else if (exc_flush) begin
          cancel_nx = 1'b1;
        end
      end
      HOLD: begin
        if (exc_flush || !stall_f) begin
          pc_nx    = next_pc;
          load_pc  = 1'b1;
          adel_nx  = 1'b0;
          state_nx = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pending redirect: exceptions dominate branches and are never overwritten by one.
  always_comb begin
    pend_exc_nx = pend_exc;
    pend_br_nx  = pend_br;
    pend_tgt_nx = pend_tgt;
    if (load_pc) begin
      pend_exc_nx = 1'b0;
      pend_br_nx  = 1'b0;
    end else if (exc_flush) begin
      pend_exc_nx = 1'b1;
      pend_br_nx  = 1'b0;
      pend_tgt_nx = exc_target;
    end else if (br_take && !pend_exc) begin
      pend_br_nx  = 1'b1;
      pend_tgt_nx = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc_f     <= RESET_PC;
      inst_f   <= '0;
      adel_q   <= 1'b0;
      cancel   <= 1'b0;
      pend_exc <= 1'b0;
      pend_br  <= 1'b0;
      pend_tgt <= '0;
    end else begin
      state    <= state_nx;
      pc_f     <= pc_nx;
      inst_f   <= inst_nx;
      adel_q   <= adel_nx;
      cancel   <= cancel_nx;
      pend_exc <= pend_exc_nx;
      pend_br  <= pend_br_nx;
      pend_tgt <= pend_tgt_nx;
    end
  end

endmodule
